// File: rtl/multi_channel_corr_pe.sv
// N-channel K-element correlation PE: per-channel dot products, channel sum, shift/saturate, PACK-wide output packing.
// Optional macro PE_ROUND_EN: round half up before the output shift.
module corr_lane #(
  parameter int DW    = 8,
  parameter int ACC_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DW-1:0]    win,
  input  logic [DW-1:0]    filt,
  output logic [ACC_W-1:0] acc
);
  logic [2*DW-1:0] prod;
  assign prod = win * filt;

  always_ff @(posedge clk)
    if (rst || clr) acc <= '0;
    else if (en)    acc <= acc + ACC_W'(prod);
endmodule

module multi_channel_corr_pe #(
  parameter int N         = 4,
  parameter int DW        = 8,
  parameter int K         = 16,
  parameter int OUT_SHIFT = 4,
  parameter int PACK      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*DW-1:0]      win_data,
  input  logic [N*DW-1:0]      filt_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PACK*DW-1:0]   out_data,
  output logic                 out_last,
  output logic                 tile_done,
  output logic                 busy
);
  localparam int ACC_W = 2*DW + $clog2(K) + $clog2(N);
  localparam int SW    = ACC_W + 1;
  localparam int CW    = $clog2(K);
  localparam int PW    = $clog2(PACK+1);
  localparam logic [CW-1:0] KM1 = CW'(K-1);
  localparam logic [PW-1:0] PM1 = PW'(PACK-1);

  typedef enum logic [1:0] {IDLE, ACCUM, REDUCE, EMIT} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]               cnt_q;
  logic [PW-1:0]               pack_cnt_q;
  logic [PACK-1:0][DW-1:0]     pack_q;
  logic                        last_q, tile_done_q;
  logic [N-1:0][ACC_W-1:0]     acc;
  logic                        accept, lane_clr;
  logic [SW-1:0]               sum, sum_adj, r;
  logic [DW-1:0]               res;

  assign accept   = in_valid & in_ready;
  assign lane_clr = (state_q == IDLE && start) || state_q == REDUCE;

  for (genvar c = 0; c < N; c++) begin : g_lane
    corr_lane #(.DW(DW), .ACC_W(ACC_W)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .clr  (lane_clr),
      .en   (accept),
      .win  (win_data[c*DW +: DW]),
      .filt (filt_data[c*DW +: DW]),
      .acc  (acc[c])
    );
  end

  always_comb begin
    sum = '0;
    for (int c = 0; c < N; c++) sum = sum + SW'(acc[c]);
  end

`ifdef PE_ROUND_EN
  localparam logic [SW-1:0] RND = SW'(1) << (OUT_SHIFT-1);
  assign sum_adj = sum + RND;
`else
  assign sum_adj = sum;
`endif
  assign r   = sum_adj >> OUT_SHIFT;
  assign res = (|r[SW-1:DW]) ? {DW{1'b1}} : r[DW-1:0];

  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE:   begin busy = 1'b0; if (start) state_d = ACCUM; end
      ACCUM:  begin in_ready = 1'b1; if (in_valid && cnt_q == KM1) state_d = REDUCE; end
      REDUCE: state_d = (pack_cnt_q == PM1 || last_q) ? EMIT : ACCUM;
      EMIT:   begin out_valid = 1'b1; if (out_ready) state_d = last_q ? IDLE : ACCUM; end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      last_q      <= 1'b0;
      pack_cnt_q  <= '0;
      pack_q      <= '0;
      tile_done_q <= 1'b0;
    end else begin
      tile_done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          cnt_q      <= '0;
          last_q     <= 1'b0;
          pack_cnt_q <= '0;
          pack_q     <= '0;
        end
        ACCUM: if (accept) begin
          cnt_q <= (cnt_q == KM1) ? '0 : cnt_q + 1'b1;
          // in_last only matters on the closing element of a dot product
          if (cnt_q == KM1) last_q <= in_last;
        end
        REDUCE: begin
          for (int j = 0; j < PACK; j++)
            if (pack_cnt_q == PW'(j)) pack_q[j] <= res;
          pack_cnt_q <= pack_cnt_q + 1'b1;
          cnt_q      <= '0;
        end
        EMIT: if (out_ready) begin
          pack_q     <= '0;
          pack_cnt_q <= '0;
          if (last_q) begin
            tile_done_q <= 1'b1;
            last_q      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data  = pack_q;
  assign out_last  = out_valid & last_q;
  assign tile_done = tile_done_q;
endmodule

// File: tb/tb_multi_channel_corr_pe.sv
// Directed + randomized bench for multi_channel_corr_pe against an arithmetic dot-product reference.
module tb_multi_channel_corr_pe;
  localparam int N = 4, DW = 8, K = 16, OUT_SHIFT = 4, PACK = 4;

  logic clk = 1'b0;
  logic rst, start, in_valid, in_ready, in_last;
  logic out_valid, out_ready, out_last, tile_done, busy;
  logic [N*DW-1:0]    win_data, filt_data;
  logic [PACK*DW-1:0] out_data;

  int n_chk = 0, n_fail = 0;
  int unsigned wv[K][N], fv[K][N];
  int unsigned exp_slots[$];
  logic [PACK*DW-1:0] obs_word;
  bit pre_rdy;

  always #5 clk = ~clk;

  multi_channel_corr_pe #(.N(N), .DW(DW), .K(K), .OUT_SHIFT(OUT_SHIFT), .PACK(PACK)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .win_data(win_data), .filt_data(filt_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .tile_done(tile_done), .busy(busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_const(input int unsigned wval, input int unsigned fval);
    for (int k = 0; k < K; k++)
      for (int c = 0; c < N; c++) begin wv[k][c] = wval; fv[k][c] = fval; end
  endtask

  task automatic fill_random();
    int unsigned mx;
    case ($urandom_range(2, 0))
      0: mx = 1;
      1: mx = 15;
      default: mx = 255;
    endcase
    for (int k = 0; k < K; k++)
      for (int c = 0; c < N; c++) begin
        wv[k][c] = $urandom_range(mx, 0);
        fv[k][c] = $urandom_range(mx, 0);
      end
  endtask

  // Reference: full dot product over all channels, optional rounding, shift, clamp.
  function automatic int unsigned model_res();
    longint unsigned s = 0;
    for (int k = 0; k < K; k++)
      for (int c = 0; c < N; c++) s += longint'(wv[k][c]) * longint'(fv[k][c]);
`ifdef PE_ROUND_EN
    s += longint'(1) << (OUT_SHIFT-1);
`endif
    s = s >> OUT_SHIFT;
    if (s > longint'((1 << DW) - 1)) return (1 << DW) - 1;
    return int'(s);
  endfunction

  task automatic send_elem(input int k, input logic lst);
    logic [N*DW-1:0] w, f;
    int t;
    for (int c = 0; c < N; c++) begin
      w[c*DW +: DW] = DW'(wv[k][c]);
      f[c*DW +: DW] = DW'(fv[k][c]);
    end
    in_valid = 1'b1; win_data = w; filt_data = f; in_last = lst;
    t = 0;
    while (!in_ready && t < 50) begin tick(); t++; end
    check("accept_wait", 64'(t < 50), 64'd1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic feed_dp(input logic lst, input bit rnd);
    for (int k = 0; k < K; k++) begin
      if (rnd && $urandom_range(3, 0) == 0) begin
        start = 1'($urandom_range(1, 0));   // stray start while busy must be ignored
        tick();
        start = 1'b0;
      end
      send_elem(k, (k == K-1) ? lst : (rnd ? 1'($urandom_range(1, 0)) : 1'b0));
    end
    exp_slots.push_back(model_res());
  endtask

  task automatic take_word(input logic lst, input int stall);
    logic [PACK*DW-1:0] ew = '0;
    foreach (exp_slots[j]) ew[j*DW +: DW] = DW'(exp_slots[j]);
    exp_slots.delete();
    check("reduce_valid", 64'(out_valid), 64'd0);
    check("reduce_in_ready", 64'(in_ready), 64'd0);
    tick();
    check("emit_valid_latency", 64'(out_valid), 64'd1);
    if (stall > 0) begin
      out_ready = 1'b0;
      in_valid = 1'b1; win_data = '1; filt_data = '1;
      for (int s = 0; s < stall; s++) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'(ew));
        check("stall_in_ready", 64'(in_ready), 64'd0);
        tick();
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    check("word_data", 64'(out_data), 64'(ew));
    check("word_last", 64'(out_last), 64'(lst));
    obs_word = out_data;
    tick();
    out_ready = pre_rdy;
    check("post_valid", 64'(out_valid), 64'd0);
    check("post_tile_done", 64'(tile_done), 64'(lst));
    check("post_busy", 64'(busy), 64'(!lst));
    check("post_in_ready", 64'(in_ready), 64'(!lst));
    if (lst) begin
      tick();
      check("tile_done_pulse", 64'(tile_done), 64'd0);
    end
  endtask

  task automatic run_dp(input logic lst, input bit rnd, input int stall);
    feed_dp(lst, rnd);
    if (exp_slots.size() == PACK || lst) take_word(lst, stall);
  endtask

  task automatic start_tile();
    start = 1'b1; tick(); start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    win_data = '0; filt_data = '0; pre_rdy = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    rst = 1'b0; tick();
    check("idle_in_ready", 64'(in_ready), 64'd0);

    // 1: four all-ones dot products, last on element 64
    start_tile(); fill_const(1, 1);
    for (int i = 0; i < 4; i++) run_dp(i == 3, 1'b0, 0);
    check("t1_word", 64'(obs_word), 64'h04040404);

    // 2: saturation
    start_tile(); fill_const(255, 255);
    run_dp(1'b1, 1'b0, 0);
    check("t2_word", 64'(obs_word), 64'h000000FF);

    // 3: partial flush
    start_tile(); fill_const(1, 1);
    run_dp(1'b0, 1'b0, 0); run_dp(1'b1, 1'b0, 0);
    check("t3_word", 64'(obs_word), 64'h00000404);
    check("t3_idle_in_ready", 64'(in_ready), 64'd0);

    // 4: output backpressure for 10 cycles
    start_tile(); fill_const(1, 1);
    for (int i = 0; i < 4; i++) run_dp(1'b0, 1'b0, (i == 3) ? 10 : 0);
    check("t4_word", 64'(obs_word), 64'h04040404);
    run_dp(1'b1, 1'b0, 0);
    check("t4_flush", 64'(obs_word), 64'h00000004);

    // 5: reset mid-accumulation leaves no residue
    start_tile(); fill_const(1, 1);
    for (int k = 0; k < 7; k++) send_elem(k, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t5_in_ready", 64'(in_ready), 64'd0);
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_out_last", 64'(out_last), 64'd0);
    check("t5_tile_done", 64'(tile_done), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_out_data", 64'(out_data), 64'd0);
    start_tile();
    run_dp(1'b1, 1'b0, 0);
    check("t5_word", 64'(obs_word), 64'h00000004);

    // 6: rounding boundary, sum 24 -> 1.5
    start_tile(); fill_const(0, 0);
    for (int k = 0; k < 8; k++) begin wv[k][0] = 3; fv[k][0] = 1; end
    run_dp(1'b1, 1'b0, 0);
`ifdef PE_ROUND_EN
    check("t6_word", 64'(obs_word), 64'h00000002);
`else
    check("t6_word", 64'(obs_word), 64'h00000001);
`endif

    // Randomized tiles
    for (int t = 0; t < 8; t++) begin
      int ndp;
      pre_rdy = 1'($urandom_range(1, 0));
      out_ready = pre_rdy;
      start_tile();
      ndp = $urandom_range(9, 1);
      for (int d = 0; d < ndp; d++) begin
        fill_random();
        run_dp(d == ndp-1, 1'b1, pre_rdy ? 0 : int'($urandom_range(3, 0)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
